io_button_ctrl: RTL and testbench
=================================

Name: io_button_ctrl

Overview:
- Memory-mapped push-button peripheral; sits directly downstream of io_deco.
- Consumes io_deco's btn_selecc together with a decoded read strobe.
- Synchronises and debounces the raw board keys, latches press events as sticky flags, and returns a 32-bit status word to the single-cycle processor's load path.
- Clears the selected button's flag on each read.

Parameters:
- N_BTN, 4, number of buttons (1..4).
- DEBOUNCE_CYCLES, 250000, cycles an input must stay stable before it is accepted (5 ms at 50 MHz); minimum 2.
- DATA_WIDTH, 32, width of rd_data.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- btn_n  in  N_BTN  raw board keys, active-low, asynchronous to clk.
- btn_selecc  in  2  button index from io_deco.
- rd_enb  in  1  decoded read strobe for the button region; one read per cycle high.
- rd_data  out  DATA_WIDTH  registered status word.
- btn_level  out  N_BTN  debounced pressed level, 1 = pressed.
- press_pending  out  1  OR of all sticky event flags.

Behaviour:
- Reset (rst=0 at an edge) clears all state:
  - sync stages, stable levels, debounce counters, event flags and rd_data go to 0.
  - btn_level = 0 and press_pending = 0.
  - Reset mid-debounce discards the partial count.
- Synchroniser: two-flop sync of ~btn_n per bit, giving sync[i].
- Debounce, per button, counter width clog2(DEBOUNCE_CYCLES):
  - If sync[i] == stable[i], the counter is set to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, then stable[i] <= sync[i] and the counter goes to 0.
  - Otherwise the counter increments.
  - Any return to equality before terminal count aborts the change; a glitch shorter than DEBOUNCE_CYCLES has no effect.
- Latency: raw press first sampled at edge k. Then btn_level[i] = 1 after edge k+1+DEBOUNCE_CYCLES. Release timing is symmetric.
- btn_level = stable. No combinational path from btn_n.
- Event flag:
  - event[i] is set on the edge where stable[i] goes 0->1.
  - Releases do not set a flag.
  - A button held through reset deasserting yields a new press event after the debounce latency. This is intended.
- Read, at an edge with rd_enb=1:
  - rd_data <= {zeros, stable[s], event[s]}, where s = btn_selecc. Bit0 = event, bit1 = level, all upper bits 0.
  - The captured value is the pre-clear value.
  - event[s] is cleared.
  - Set and clear of the same flag on the same edge: the set wins and the flag stays 1. rd_data bit0 reports the old value.
- rd_enb=0: rd_data holds its last value.
- rd_enb held for multiple cycles: each cycle is a separate read. A second consecutive read of the same button returns bit0 = 0.
- btn_selecc >= N_BTN: rd_data <= 0 and no flag is cleared.
- Reads of button s never affect other flags.
- Read latency: 1 cycle. rd_data is valid the cycle after rd_enb. The processor's load path must tolerate this.
- press_pending is combinational OR of the event registers.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and N_BTN=4.
1. Reset: rst=0 for 3 cycles while btn_n=4'b0000 -> rd_data=0, btn_level=0, press_pending=0 throughout. After release, btn_level=4'b1111 exactly 5 edges later, and press_pending=1.
2. Press and read:
   - btn_n[1]=0 from edge k -> btn_level[1]=1 after edge k+5, press_pending=1.
   - btn_selecc=1, rd_enb=1 for one cycle -> next cycle rd_data=32'h3 and press_pending=0.
   - Second read -> rd_data=32'h2.
3. Glitch: btn_n[0] low for 3 cycles, then high -> btn_level[0] never 1, event[0] stays 0, and a read of button 0 returns 32'h0.
4. Simultaneous set/clear: button 3 debounces and its stable edge coincides with an rd_enb read of button 3 -> rd_data=32'h2 (level 1, old event 0). A following read returns 32'h3.
5. Isolation: button 2 pressed, then button 0 read -> rd_data=32'h0 and press_pending stays 1. A subsequent read of button 2 returns 32'h3.
6. Reset mid-debounce: btn_n[1]=0 for 3 edges, rst=0 for one edge, then rst=1 -> btn_level[1] rises only 5 edges after reset release (full latency restarts), and an event is latched.

Source files
------------

// File: rtl/io_button_ctrl.sv
// Memory-mapped push-button peripheral: synchronises and debounces raw keys,
// latches press events as sticky flags and returns a status word on read.
module io_button_ctrl #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn_n,
  input  logic [1:0]            btn_selecc,
  input  logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [N_BTN-1:0]      btn_level,
  output logic                  press_pending
);

  localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]      sync1_q, sync1_d;
  logic [N_BTN-1:0]      sync2_q, sync2_d;
  logic [N_BTN-1:0]      stable_q, stable_d;
  logic [N_BTN-1:0]      event_q, event_d;
  logic [CNT_W-1:0]      cnt_q [N_BTN];
  logic [CNT_W-1:0]      cnt_d [N_BTN];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    sync1_d   = ~btn_n;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    event_d   = event_q;
    rd_data_d = rd_data_q;

    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    // Level bit reports the newly accepted level; event bit reports the pre-clear flag.
    if (rd_enb) begin
      rd_data_d = '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_selecc == 2'(i)) begin
          rd_data_d[1] = stable_d[i];
          rd_data_d[0] = event_q[i];
          event_d[i]   = 1'b0;
        end
      end
    end

    // Applied after the read clear so a coincident press keeps the flag set.
    for (int i = 0; i < N_BTN; i++) begin
      if (stable_d[i] && !stable_q[i]) begin
        event_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      event_q   <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      event_q   <= event_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_data       = rd_data_q;
  assign btn_level     = stable_q;
  assign press_pending = |event_q;

endmodule

// File: tb/tb_io_button_ctrl.sv
// Directed bench for io_button_ctrl with DEBOUNCE_CYCLES=4, N_BTN=4.
module tb_io_button_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn_n;
  logic [1:0]  btn_selecc;
  logic        rd_enb;
  logic [31:0] rd_data;
  logic [3:0]  btn_level;
  logic        press_pending;

  int total = 0;
  int bad   = 0;

  io_button_ctrl #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .btn_selecc(btn_selecc),
    .rd_enb(rd_enb),
    .rd_data(rd_data),
    .btn_level(btn_level),
    .press_pending(press_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  btn_n;
    logic [1:0]  sel;
    logic        rd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_lvl;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic r, logic [3:0] b, logic [1:0] s, logic rd,
                              logic [31:0] erd, logic [3:0] elvl, logic epend);
    vec_t v;
    v.rst = r; v.btn_n = b; v.sel = s; v.rd = rd;
    v.exp_rd = erd; v.exp_lvl = elvl; v.exp_pend = epend;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic drive(logic r, logic [3:0] b, logic [1:0] s, logic rd);
    rst = r; btn_n = b; btn_selecc = s; rd_enb = rd;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(string tag, logic [31:0] erd, logic [3:0] elvl, logic epend);
    total++;
    if (rd_data !== erd) begin
      bad++;
      $display("FAIL %s rd_data got=%h want=%h", tag, rd_data, erd);
    end
    total++;
    if (btn_level !== elvl) begin
      bad++;
      $display("FAIL %s btn_level got=%b want=%b", tag, btn_level, elvl);
    end
    total++;
    if (press_pending !== epend) begin
      bad++;
      $display("FAIL %s press_pending got=%b want=%b", tag, press_pending, epend);
    end
  endtask

  initial begin
    drive(1'b0, 4'b0000, 2'd0, 1'b0);

    // reset with all keys held, then all four debounce together
    add(3, 0, 4'b0000, 0, 0, 32'h0, 4'h0, 0);
    add(5, 1, 4'b0000, 0, 0, 32'h0, 4'h0, 0);
    add(1, 1, 4'b0000, 0, 0, 32'h0, 4'hF, 1);
    // drain the four events, then a repeated read of button 3
    add(1, 1, 4'b0000, 0, 1, 32'h3, 4'hF, 1);
    add(1, 1, 4'b0000, 1, 1, 32'h3, 4'hF, 1);
    add(1, 1, 4'b0000, 2, 1, 32'h3, 4'hF, 1);
    add(1, 1, 4'b0000, 3, 1, 32'h3, 4'hF, 0);
    add(1, 1, 4'b0000, 3, 1, 32'h2, 4'hF, 0);
    // release: level drops after full latency, no event, rd_data holds
    add(5, 1, 4'b1111, 0, 0, 32'h2, 4'hF, 0);
    add(1, 1, 4'b1111, 0, 0, 32'h2, 4'h0, 0);
    // press button 1 and read it twice
    add(5, 1, 4'b1101, 0, 0, 32'h2, 4'h0, 0);
    add(1, 1, 4'b1101, 0, 0, 32'h2, 4'h2, 1);
    add(1, 1, 4'b1101, 1, 1, 32'h3, 4'h2, 0);
    add(1, 1, 4'b1101, 1, 1, 32'h2, 4'h2, 0);
    add(1, 1, 4'b1101, 1, 0, 32'h2, 4'h2, 0);
    // 3-cycle glitch on button 0 is rejected
    add(3, 1, 4'b1100, 0, 0, 32'h2, 4'h2, 0);
    add(2, 1, 4'b1101, 0, 0, 32'h2, 4'h2, 0);
    add(1, 1, 4'b1101, 0, 1, 32'h0, 4'h2, 0);
    // release button 1
    add(5, 1, 4'b1111, 0, 0, 32'h0, 4'h2, 0);
    add(1, 1, 4'b1111, 0, 0, 32'h0, 4'h0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].btn_n, vecs[i].sel, vecs[i].rd);
      step();
      check($sformatf("row%0d", i), vecs[i].exp_rd, vecs[i].exp_lvl, vecs[i].exp_pend);
    end

    // set/clear coincidence on button 3: the read lands on the accepting edge
    drive(1, 4'b0111, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("b3_wait%0d", i), 32'h0, 4'h0, 0);
    end
    drive(1, 4'b0111, 3, 1);
    step();
    check("b3_coincide", 32'h2, 4'h8, 1);
    step();
    check("b3_reread", 32'h3, 4'h8, 0);

    // isolation: pressed button 2 is not touched by a read of button 0
    drive(1, 4'b0011, 0, 0);
    for (int i = 0; i < 6; i++) step();
    check("b2_pressed", 32'h3, 4'hC, 1);
    drive(1, 4'b0011, 0, 1);
    step();
    check("b0_read", 32'h0, 4'hC, 1);
    drive(1, 4'b0011, 2, 1);
    step();
    check("b2_read", 32'h3, 4'hC, 0);

    // reset mid-debounce restarts the full latency
    drive(1, 4'b1111, 0, 0);
    for (int i = 0; i < 6; i++) step();
    check("all_released", 32'h3, 4'h0, 0);
    drive(1, 4'b1101, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("pre_rst%0d", i), 32'h3, 4'h0, 0);
    end
    drive(0, 4'b1101, 0, 0);
    step();
    check("mid_rst", 32'h0, 4'h0, 0);
    drive(1, 4'b1101, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_rst%0d", i), 32'h0, 4'h0, 0);
    end
    step();
    check("post_rst_level", 32'h0, 4'h2, 1);
    drive(1, 4'b1101, 1, 1);
    step();
    check("post_rst_read", 32'h3, 4'h2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
